// File: rtl/load_use_stall_ctrl.sv
// Load-use hazard interlock: freezes PC and IF/ID and injects ID/EX bubbles
// for STALL_CYCLES cycles when the ID instruction reads a register being loaded in EX.
//
// state | meaning
// IDLE  | no stall in progress; hazard detection live
// STALL | extra bubble cycles pending (STALL_CYCLES > 1 only); hazard ignored
module load_use_stall_ctrl #(
  parameter int unsigned STALL_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_ex_lw,
  input  logic [4:0]  id_ex_rt,
  input  logic [4:0]  if_id_rs,
  input  logic [4:0]  if_id_rt,
  input  logic        if_id_uses_rt,
  input  logic        if_id_valid,
  input  logic        flush,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_bubble,
  output logic        stall_active,
  output logic [15:0] stall_count
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] STALL = 1'b1;
  localparam logic [1:0] REM_INIT = 2'(STALL_CYCLES - 1);

  logic [0:0] state, state_nxt;
  logic [1:0] rem, rem_nxt;
  logic       hazard;
  logic       bubble;

  // $0 is hardwired to zero, so a load targeting it can never feed a consumer.
  assign hazard = id_ex_lw & if_id_valid & ~flush & (id_ex_rt != 5'd0) &
                  ((id_ex_rt == if_id_rs) | (if_id_uses_rt & (id_ex_rt == if_id_rt)));

  always_comb begin
    bubble    = 1'b0;
    state_nxt = state;
    rem_nxt   = rem;
    if (reset) begin
      bubble    = 1'b0;
      state_nxt = IDLE;
      rem_nxt   = 2'd0;
    end else if (state == STALL) begin
      if (flush) begin
        state_nxt = IDLE;
        rem_nxt   = 2'd0;
      end else begin
        bubble = 1'b1;
        if (rem <= 2'd1) begin
          state_nxt = IDLE;
          rem_nxt   = 2'd0;
        end else begin
          rem_nxt = rem - 2'd1;
        end
      end
    end else if (hazard) begin
      bubble = 1'b1;
      if (STALL_CYCLES > 1) begin
        state_nxt = STALL;
        rem_nxt   = REM_INIT;
      end
    end
  end

  assign id_ex_bubble = bubble;
  assign pc_write     = ~bubble;
  assign if_id_write  = ~bubble;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rem          <= 2'd0;
      stall_active <= 1'b0;
      stall_count  <= 16'd0;
    end else begin
      state        <= state_nxt;
      rem          <= rem_nxt;
      stall_active <= (state_nxt == STALL);
      if (bubble && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_load_use_stall_ctrl.sv
// Directed bench for load_use_stall_ctrl: one instance with STALL_CYCLES=1 and one with 3,
// sharing stimulus; the instance not under test is held in reset.
module tb_load_use_stall_ctrl;

  logic        clock = 1'b0;
  logic        rst1, rst3;
  logic        id_ex_lw, if_id_uses_rt, if_id_valid, flush;
  logic [4:0]  id_ex_rt, if_id_rs, if_id_rt;
  logic        pw1, iw1, bb1, sa1;
  logic        pw3, iw3, bb3, sa3;
  logic [15:0] sc1, sc3;
  int          n_assert = 0;
  int          n_fail   = 0;

  always #5 clock = ~clock;

  load_use_stall_ctrl #(.STALL_CYCLES(1)) u1 (
    .clock(clock), .reset(rst1), .id_ex_lw(id_ex_lw), .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .if_id_valid(if_id_valid), .flush(flush), .pc_write(pw1), .if_id_write(iw1),
    .id_ex_bubble(bb1), .stall_active(sa1), .stall_count(sc1));

  load_use_stall_ctrl #(.STALL_CYCLES(3)) u3 (
    .clock(clock), .reset(rst3), .id_ex_lw(id_ex_lw), .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .if_id_valid(if_id_valid), .flush(flush), .pc_write(pw3), .if_id_write(iw3),
    .id_ex_bubble(bb3), .stall_active(sa3), .stall_count(sc3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // pc_write/if_id_write/bubble expected together from a single "stalling" flag
  task automatic chk_ctl1(input string tag, input logic stall);
    chk({tag, ".pc_write"}, {31'd0, pw1}, {31'd0, ~stall});
    chk({tag, ".if_id_write"}, {31'd0, iw1}, {31'd0, ~stall});
    chk({tag, ".bubble"}, {31'd0, bb1}, {31'd0, stall});
  endtask

  task automatic chk_ctl3(input string tag, input logic stall, input logic active);
    chk({tag, ".pc_write"}, {31'd0, pw3}, {31'd0, ~stall});
    chk({tag, ".if_id_write"}, {31'd0, iw3}, {31'd0, ~stall});
    chk({tag, ".bubble"}, {31'd0, bb3}, {31'd0, stall});
    chk({tag, ".stall_active"}, {31'd0, sa3}, {31'd0, active});
  endtask

  task automatic set_in(input logic lw, input logic [4:0] rt_ex, input logic [4:0] rs,
                        input logic [4:0] rt, input logic uses_rt, input logic valid,
                        input logic fl);
    id_ex_lw = lw; id_ex_rt = rt_ex; if_id_rs = rs; if_id_rt = rt;
    if_id_uses_rt = uses_rt; if_id_valid = valid; flush = fl;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst1 = 1'b1; rst3 = 1'b1;
    // hazard pattern on the inputs while in reset must not stall
    set_in(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0);
    #2;
    chk_ctl1("reset", 1'b0);
    chk("reset.count", {16'd0, sc1}, 32'd0);
    chk("reset.active", {31'd0, sa1}, 32'd0);
    chk_ctl3("reset3", 1'b0, 1'b0);

    // single-cycle load-use stall on rs
    @(negedge clock); set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); rst1 = 1'b0;
    @(negedge clock); set_in(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0);
    #1 chk_ctl1("sc1.hazard", 1'b1);
    @(negedge clock); id_ex_lw = 1'b0;
    #1 chk_ctl1("sc1.release", 1'b0);
    chk("sc1.count", {16'd0, sc1}, 32'd1);
    chk("sc1.active", {31'd0, sa1}, 32'd0);

    // $0 and unused-rt cases do not stall; used rt does
    @(negedge clock); set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    #1 chk_ctl1("r0", 1'b0);
    @(negedge clock); set_in(1'b1, 5'd8, 5'd3, 5'd8, 1'b0, 1'b1, 1'b0);
    #1 chk_ctl1("rt_unused", 1'b0);
    @(negedge clock); if_id_uses_rt = 1'b1;
    #1 chk_ctl1("rt_used", 1'b1);
    @(negedge clock); set_in(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1);
    #1 chk_ctl1("flush_masks", 1'b0);
    @(negedge clock); set_in(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
    #1 chk_ctl1("invalid", 1'b0);
    @(negedge clock); id_ex_lw = 1'b0;
    #1 chk("sc1.count2", {16'd0, sc1}, 32'd2);

    // three-cycle stall on rt=9
    rst1 = 1'b1; rst3 = 1'b0;
    @(negedge clock); set_in(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b1, 1'b0);
    #1 chk_ctl3("sc3.c1", 1'b1, 1'b0);
    @(negedge clock);
    #1 chk_ctl3("sc3.c2", 1'b1, 1'b1);
    @(negedge clock); id_ex_lw = 1'b0;
    #1 chk_ctl3("sc3.c3", 1'b1, 1'b1);
    @(negedge clock);
    #1 chk_ctl3("sc3.c4", 1'b0, 1'b0);
    chk("sc3.count", {16'd0, sc3}, 32'd3);

    // flush in the second stall cycle
    @(negedge clock); rst3 = 1'b1;
    #1 chk("sc3.rst_count", {16'd0, sc3}, 32'd0);
    @(negedge clock); rst3 = 1'b0;
    @(negedge clock); set_in(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b1, 1'b0);
    #1 chk_ctl3("fl.c1", 1'b1, 1'b0);
    @(negedge clock); id_ex_lw = 1'b0; flush = 1'b1;
    #1 chk_ctl3("fl.c2", 1'b0, 1'b1);
    @(negedge clock); flush = 1'b0;
    #1 chk_ctl3("fl.c3", 1'b0, 1'b0);
    chk("fl.count", {16'd0, sc3}, 32'd1);

    // asynchronous reset in the middle of a stall
    @(negedge clock); set_in(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clock); id_ex_lw = 1'b0;
    #1 chk_ctl3("ar.stall", 1'b1, 1'b1);
    #1 rst3 = 1'b1;
    #1 chk_ctl3("ar.async", 1'b0, 1'b0);
    chk("ar.count", {16'd0, sc3}, 32'd0);
    @(negedge clock); rst3 = 1'b0;
    @(negedge clock);
    #1 chk_ctl3("ar.after", 1'b0, 1'b0);
    chk("ar.count2", {16'd0, sc3}, 32'd0);

    // back-to-back hazards drive the counter into saturation
    rst3 = 1'b1;
    @(negedge clock); rst1 = 1'b0; set_in(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0);
    repeat (65534) @(posedge clock);
    #1 chk("sat.fffe", {16'd0, sc1}, 32'h0000_FFFE);
    @(posedge clock);
    #1 chk("sat.ffff", {16'd0, sc1}, 32'h0000_FFFF);
    repeat (3) @(posedge clock);
    #1 chk("sat.hold", {16'd0, sc1}, 32'h0000_FFFF);
    chk_ctl1("sat.ctl", 1'b1);
    chk("sat.active", {31'd0, sa1}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
